// File: rtl/multdiv_seq.sv
// Multicycle signed multiplier/divider, the sequential companion to the single-cycle ALU.
// MULT is radix-2 Booth; DIV is restoring division on magnitudes followed by sign correction.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   data_operandA/data_operandB   multiplicand/dividend and multiplier/divisor, two's complement
//   ctrl_MULT/ctrl_DIV            one-cycle start pulses (MULT wins if both are high)
//   data_result                   low WIDTH bits of the product, or the quotient
//   data_exception                overflow / divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY                one-cycle completion pulse
//   busy                          operation in flight
module multdiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_mult;

  // Booth register {bp, bq, bq1}; bp carries one extra sign bit so that
  // subtracting the most-negative multiplicand cannot wrap.
  logic [WIDTH:0]   bp;
  logic [WIDTH-1:0] bq;
  logic             bq1;

  // Restoring divider: partial remainder, dividend/quotient shift register, divisor magnitude.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;

  logic             start;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic             div_take;
  logic [2*WIDTH-1:0] product;
  logic             mul_ovf;
  logic [WIDTH-1:0] quo_signed;
  logic             div_ovf;

  assign start = ctrl_MULT | ctrl_DIV;

  // Per-iteration datapath and final result/exception formation.
  always_comb begin
    a_mag      = data_operandA[WIDTH-1] ? (WIDTH'(0) - data_operandA) : data_operandA;
    b_mag      = data_operandB[WIDTH-1] ? (WIDTH'(0) - data_operandB) : data_operandB;
    a_ext      = {op_a[WIDTH-1], op_a};
    booth_sum  = bp;
    case ({bq[0], bq1})
      2'b01:   booth_sum = bp + a_ext;
      2'b10:   booth_sum = bp - a_ext;
      default: booth_sum = bp;
    endcase
    rem_shift  = {rem, quo[WIDTH-1]};
    div_take   = (rem_shift >= {1'b0, dvs});
    product    = {bp[WIDTH-1:0], bq};
    mul_ovf    = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
    quo_signed = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) ? (WIDTH'(0) - quo) : quo;
    div_ovf    = (op_a == MOST_NEG) && (op_b == {WIDTH{1'b1}});
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_a           <= '0;
      op_b           <= '0;
      op_mult        <= 1'b0;
      bp             <= '0;
      bq             <= '0;
      bq1            <= 1'b0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // A start in any state (including mid-operation) restarts from scratch.
        op_a    <= data_operandA;
        op_b    <= data_operandB;
        op_mult <= ctrl_MULT;
        cnt     <= '0;
        busy    <= 1'b1;
        bp      <= '0;
        bq      <= data_operandB;
        bq1     <= 1'b0;
        rem     <= '0;
        quo     <= a_mag;
        dvs     <= b_mag;
        state   <= ctrl_MULT ? S_MULT : S_DIV;
      end else begin
        case (state)
          S_MULT: begin
            bp  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            bq  <= {booth_sum[0], bq[WIDTH-1:1]};
            bq1 <= bq[0];
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) state <= S_DONE;
          end
          S_DIV: begin
            if (op_b == '0) begin
              // Divide by zero finishes on the first iteration edge.
              data_result    <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
              state          <= S_IDLE;
            end else begin
              rem <= div_take ? WIDTH'(rem_shift - {1'b0, dvs}) : WIDTH'(rem_shift);
              quo <= {quo[WIDTH-2:0], div_take};
              cnt <= cnt + CNT_W'(1);
              if (cnt == LAST_ITER) state <= S_DONE;
            end
          end
          S_DONE: begin
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= S_IDLE;
            if (op_mult) begin
              data_result    <= product[WIDTH-1:0];
              data_exception <= mul_ovf;
            end else begin
              data_result    <= quo_signed;
              data_exception <= div_ovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
